// File: rtl/lc3b_pkg.sv
// Shared LC-3b definitions: memory FSM state encoding, default latency and
// the request encodings also driven by the control store.
package lc3b_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  localparam int MEM_LATENCY = 5;

  localparam logic R_W_READ  = 1'b0;
  localparam logic R_W_WRITE = 1'b1;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  // Byte lanes written for a request; a byte write to an odd address hits the high lane.
  function automatic logic [1:0] byte_enable(input logic size, input logic a0);
    logic [1:0] be;
    be = 2'b11;
    case (size)
      SIZE_WORD: be = 2'b11;
      SIZE_BYTE: be = a0 ? 2'b10 : 2'b01;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lc3b_mem_array.sv
// 2^ADDR_W x 16 word store with a byte-enabled synchronous write port and a
// registered, enabled read port whose output holds until the next read.
module lc3b_mem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [1:0]        be_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [15:0]       wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [15:0]       rdata_o
);

  logic [15:0] mem_q [2**ADDR_W];
  logic [15:0] rdata_q;

  // NOTE: the storage array has no reset, so contents survive a reset and it maps onto RAM.
  always_ff @(posedge clk_i) begin
    if (we_i && be_i[0]) mem_q[waddr_i][7:0]  <= wdata_i[7:0];
    if (we_i && be_i[1]) mem_q[waddr_i][15:8] <= wdata_i[15:8];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory-side responder: accepts a request, counts out the fixed memory
// latency, performs the access on the ready edge and pulses R for one cycle.
module lc3b_mem_responder
  import lc3b_pkg::*;
#(
  parameter int LATENCY = MEM_LATENCY,
  parameter int ADDR_W  = 10
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic        data_size,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready
);

  localparam int CNT_W = $clog2(LATENCY);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic              size_q, size_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              mem_we, mem_re;
  logic [1:0]        mem_be;

  // Address bits above the array's byte range are don't-care: accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[15:ADDR_W+1];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mio_en) begin
          rw_d    = r_w;
          size_d  = data_size;
          addr_d  = addr[ADDR_W:0];
          wdata_d = wdata;
          cnt_d   = CNT_W'(LATENCY - 2);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!mio_en) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_READY;
          ready_d = 1'b1;
          mem_we  = (rw_q == R_W_WRITE);
          mem_re  = (rw_q == R_W_READ);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_READY: begin
        // Leaving unconditionally keeps a held request from being re-accepted this edge.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    // NOTE: non-blocking assignments so every register updates together at the edge.
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      size_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
    end
  end

  assign mem_be = byte_enable(size_q, addr_q[0]);

  lc3b_mem_array #(
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk_i   (clock_50),
    .rst_i   (reset),
    .we_i    (mem_we),
    .be_i    (mem_be),
    .waddr_i (addr_q[ADDR_W:1]),
    .wdata_i (wdata_q),
    .re_i    (mem_re),
    .raddr_i (addr_q[ADDR_W:1]),
    .rdata_o (rdata)
  );

  assign ready = ready_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Self-checking bench for lc3b_mem_responder: directed scenarios plus a
// randomized phase checked against a word-array reference model.
module tb_lc3b_mem_responder;

  localparam int L  = 5;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        mio_en;
  logic        r_w;
  logic        data_size;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ready;

  always #5 clk = ~clk;

  lc3b_mem_responder #(
    .LATENCY (L),
    .ADDR_W  (AW)
  ) dut (
    .clock_50  (clk),
    .reset     (rst),
    .mio_en    (mio_en),
    .r_w       (r_w),
    .data_size (data_size),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] mdl [1<<AW];
  logic [15:0] last_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [15:0] a);
    return int'(a[AW:1]);
  endfunction

  function automatic void mdl_write(input logic sz, input logic [15:0] a, input logic [15:0] wd);
    int w;
    w = widx(a);
    if (sz)        mdl[w] = wd;
    else if (a[0]) mdl[w][15:8] = wd[15:8];
    else           mdl[w][7:0] = wd[7:0];
  endfunction

  // One complete access as the control store would run it; inputs are
  // scrambled after acceptance to show they are ignored.
  task automatic access(input string tag, input logic rw, input logic sz,
                        input logic [15:0] a, input logic [15:0] wd);
    int          first;
    int          pulses;
    logic [15:0] exp;
    first  = -1;
    pulses = 0;
    @(negedge clk);
    mio_en = 1'b1; r_w = rw; data_size = sz; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    addr = ~a; wdata = ~wd; r_w = ~rw; data_size = ~sz;
    for (int i = 1; i <= 2*L; i++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        pulses++;
        if (first < 0) first = i;
        mio_en = 1'b0;
      end
    end
    if (rw == 1'b0) begin
      exp = mdl[widx(a)];
      last_rd = exp;
    end else begin
      exp = last_rd;
      mdl_write(sz, a, wd);
    end
    chk({tag, "/ready_edge"}, first, L - 1);
    chk({tag, "/ready_pulses"}, pulses, 1);
    chk({tag, "/rdata"}, rdata, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pulses;
    int          e1, e2;
    logic [15:0] r1, r2;
    logic [15:0] a;

    foreach (mdl[i]) mdl[i] = 16'h0000;
    last_rd = 16'h0000;
    rst = 1'b1; mio_en = 1'b0; r_w = 1'b0; data_size = 1'b0; addr = '0; wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset/ready", ready, 1'b0);
    chk("reset/rdata", rdata, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset/ready", ready, 1'b0);

    // Known contents for every word the directed and random phases read.
    access("pre_10", 1'b1, 1'b1, 16'h0010, 16'h0000);
    access("pre_20", 1'b1, 1'b1, 16'h0020, 16'h0000);
    access("pre_42", 1'b1, 1'b1, 16'h0042, 16'($urandom));
    for (int i = 0; i < 16; i++)
      access("pre_pool", 1'b1, 1'b1, 16'h0100 + 16'(2*i), 16'($urandom));

    access("word_wr", 1'b1, 1'b1, 16'h0040, 16'h1234);
    access("word_rd", 1'b0, 1'b1, 16'h0040, 16'h0000);
    chk("word_rd/value", rdata, 16'h1234);

    access("byte_wr_hi", 1'b1, 1'b0, 16'h0041, 16'hABAB);
    access("byte_wr_lo", 1'b1, 1'b0, 16'h0040, 16'hCDCD);
    access("byte_rd", 1'b0, 1'b1, 16'h0040, 16'h0000);
    chk("byte_rd/value", rdata, 16'hABCD);

    // Abort: mio_en seen low at the third edge after acceptance.
    @(negedge clk);
    mio_en = 1'b1; r_w = 1'b1; data_size = 1'b1; addr = 16'h0010; wdata = 16'hFFFF;
    @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mio_en = 1'b0;
    pulses = 0;
    repeat (2*L) begin
      @(posedge clk);
      #1;
      if (ready) pulses++;
    end
    chk("abort/ready_pulses", pulses, 0);
    access("abort_rd", 1'b0, 1'b1, 16'h0010, 16'h0000);
    chk("abort_rd/value", rdata, 16'h0000);

    // Reset in the third cycle of a write, with rdata non-zero beforehand.
    access("pre_rst_rd", 1'b0, 1'b1, 16'h0040, 16'h0000);
    @(negedge clk);
    mio_en = 1'b1; r_w = 1'b1; data_size = 1'b1; addr = 16'h0020; wdata = 16'h5555;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid/ready", ready, 1'b0);
    chk("rst_mid/rdata", rdata, 16'h0000);
    mio_en = 1'b0;
    last_rd = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (2*L) begin
      @(posedge clk);
      #1;
      if (ready) pulses++;
    end
    chk("rst_mid/no_ready", pulses, 0);
    access("rst_rd", 1'b0, 1'b1, 16'h0020, 16'h0000);
    chk("rst_rd/value", rdata, 16'h0000);

    // Back-to-back reads with mio_en held, address switched on ready.
    @(negedge clk);
    mio_en = 1'b1; r_w = 1'b0; data_size = 1'b1; addr = 16'h0040; wdata = 16'h0000;
    @(posedge clk);
    e1 = -1; e2 = -1; pulses = 0; r1 = '0; r2 = '0;
    for (int i = 1; i <= 2*L + 3; i++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        pulses++;
        if (e1 < 0) begin
          e1 = i; r1 = rdata; addr = 16'h0042;
        end else begin
          e2 = i; r2 = rdata; mio_en = 1'b0;
        end
      end
    end
    chk("b2b/first_edge", e1, L - 1);
    chk("b2b/second_edge", e2, 2*L);
    chk("b2b/pulses", pulses, 2);
    chk("b2b/first_rdata", r1, mdl[widx(16'h0040)]);
    chk("b2b/second_rdata", r2, mdl[widx(16'h0042)]);
    last_rd = mdl[widx(16'h0042)];

    access("wrap_wr", 1'b1, 1'b1, 16'h0802, 16'h9999);
    access("wrap_rd", 1'b0, 1'b1, 16'h0002, 16'h0000);
    chk("wrap_rd/value", rdata, 16'h9999);

    // Random mix over the preloaded pool, with random upper (wrapped) address bits.
    for (int n = 0; n < 40; n++) begin
      a = {5'($urandom), 10'(10'h080 + 10'($urandom_range(0, 15))), 1'($urandom)};
      access("rand", 1'($urandom), 1'($urandom), a, 16'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
